// File: rtl/aq_axilm_master.sv
// rtl/aq_axilm_master.sv - AXI4-Lite master turning single local commands into one outstanding transaction.
// Optional response timeout is compiled in with `define AQ_AXILM_TIMEOUT_EN.
module aq_axilm_master #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        LOCAL_CS,
    input  logic        LOCAL_RNW,
    input  logic [31:0] LOCAL_ADDR,
    input  logic [3:0]  LOCAL_BE,
    input  logic [31:0] LOCAL_WDATA,
    output logic        LOCAL_BUSY,
    output logic        LOCAL_ACK,
    output logic [31:0] LOCAL_RDATA,
    output logic [1:0]  LOCAL_RESP,
    output logic [31:0] M_AXI_AWADDR,
    output logic [3:0]  M_AXI_AWCACHE,
    output logic [2:0]  M_AXI_AWPROT,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    input  logic [1:0]  M_AXI_BRESP,
    output logic [31:0] M_AXI_ARADDR,
    output logic [3:0]  M_AXI_ARCACHE,
    output logic [2:0]  M_AXI_ARPROT,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_WRESP, S_READ, S_RDATA, S_ACK} state_t;

    state_t      state_q, state_d;
    logic        aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic [3:0]  be_q;
    logic [1:0]  resp_q, resp_d;
    logic        accept, timeout;

    assign accept = (state_q == S_IDLE) && LOCAL_CS;

`ifdef AQ_AXILM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (state_q inside {S_WRITE, S_WRESP, S_READ, S_RDATA}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the cycle the counter would reach TIMEOUT_CYCLES.
    assign timeout = (cnt_q == CNT_LAST) && (state_q inside {S_WRITE, S_WRESP, S_READ, S_RDATA});
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= S_IDLE;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            if (accept) begin
                addr_q  <= LOCAL_ADDR;
                wdata_q <= LOCAL_WDATA;
                be_q    <= LOCAL_BE;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            S_IDLE: begin
                if (LOCAL_CS) begin
                    state_d   = LOCAL_RNW ? S_READ : S_WRITE;
                    aw_pend_d = !LOCAL_RNW;
                    w_pend_d  = !LOCAL_RNW;
                end
            end
            S_WRITE: begin
                aw_pend_d = aw_pend_q && !M_AXI_AWREADY;
                w_pend_d  = w_pend_q && !M_AXI_WREADY;
                if (!aw_pend_d && !w_pend_d) begin
                    state_d = S_WRESP;
                end else if (timeout) begin
                    state_d   = S_ACK;
                    aw_pend_d = 1'b0;
                    w_pend_d  = 1'b0;
                    resp_d    = 2'b11;
                    rdata_d   = '0;
                end
            end
            S_WRESP: begin
                if (M_AXI_BVALID) begin
                    state_d = S_ACK;
                    resp_d  = M_AXI_BRESP;
                end else if (timeout) begin
                    state_d = S_ACK;
                    resp_d  = 2'b11;
                    rdata_d = '0;
                end
            end
            S_READ: begin
                if (M_AXI_ARREADY) begin
                    state_d = S_RDATA;
                end else if (timeout) begin
                    state_d = S_ACK;
                    resp_d  = 2'b11;
                    rdata_d = '0;
                end
            end
            S_RDATA: begin
                if (M_AXI_RVALID) begin
                    state_d = S_ACK;
                    rdata_d = M_AXI_RDATA;
                    resp_d  = M_AXI_RRESP;
                end else if (timeout) begin
                    state_d = S_ACK;
                    resp_d  = 2'b11;
                    rdata_d = '0;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode straight from state so reset clears them asynchronously.
    assign M_AXI_AWVALID = (state_q == S_WRITE) && aw_pend_q;
    assign M_AXI_WVALID  = (state_q == S_WRITE) && w_pend_q;
    assign M_AXI_BREADY  = (state_q == S_WRESP);
    assign M_AXI_ARVALID = (state_q == S_READ);
    assign M_AXI_RREADY  = (state_q == S_RDATA);

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = be_q;
    assign M_AXI_AWCACHE = 4'b0011;
    assign M_AXI_ARCACHE = 4'b0011;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;

    assign LOCAL_BUSY  = (state_q != S_IDLE);
    assign LOCAL_ACK   = (state_q == S_ACK);
    assign LOCAL_RDATA = rdata_q;
    assign LOCAL_RESP  = resp_q;

endmodule

// File: tb/tb_aq_axilm_master.sv
// tb/tb_aq_axilm_master.sv - randomized self-checking bench for aq_axilm_master against a delay-driven slave model.
module tb_aq_axilm_master;

    logic        ACLK, ARESETN;
    logic        LOCAL_CS, LOCAL_RNW;
    logic [31:0] LOCAL_ADDR, LOCAL_WDATA, LOCAL_RDATA;
    logic [3:0]  LOCAL_BE;
    logic        LOCAL_BUSY, LOCAL_ACK;
    logic [1:0]  LOCAL_RESP;
    logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
    logic [3:0]  M_AXI_AWCACHE, M_AXI_WSTRB, M_AXI_ARCACHE;
    logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RVALID, M_AXI_RREADY;
    logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;

    aq_axilm_master #(.TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .LOCAL_CS(LOCAL_CS), .LOCAL_RNW(LOCAL_RNW), .LOCAL_ADDR(LOCAL_ADDR),
        .LOCAL_BE(LOCAL_BE), .LOCAL_WDATA(LOCAL_WDATA), .LOCAL_BUSY(LOCAL_BUSY),
        .LOCAL_ACK(LOCAL_ACK), .LOCAL_RDATA(LOCAL_RDATA), .LOCAL_RESP(LOCAL_RESP),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARCACHE(M_AXI_ARCACHE),
        .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
        .M_AXI_RREADY(M_AXI_RREADY)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Slave configuration, written by the test process only.
    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    logic [3:0]  cur_be = '0;
    int flush_req = 0;

    // Slave state and observations, written by the slave process only.
    int flush_seen = 0, viol = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0;
    int hs_aw = -1, hs_w = -1, hs_b = -1, hs_ar = -1, hs_r = -1;
    logic [31:0] got_addr = '0, got_wdata = '0, ar_a = '0;
    logic [3:0]  got_strb = '0;
    logic [31:0] smem [logic [31:0]];
    logic [31:0] aw_log [$];

    // Reference memory, written by the test process only.
    logic [31:0] mmem [logic [31:0]];

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        forever begin
            @(posedge ACLK);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return mmem.exists(a) ? mmem[a] : 32'h0;
    endfunction

    // Expected cycle of LOCAL_ACK relative to the command cycle, from the channel delays.
    function automatic int model_lat(input logic rnw);
        int a, w, d;
        if (rnw) return 1 + ar_delay + 1 + r_delay + 1;
        a = 1 + aw_delay;
        w = 1 + w_delay;
        d = (a > w) ? a : w;
        return d + 1 + b_delay + 1;
    endfunction

    // Slave: decides READY/VALID at the falling edge; a handshake seen here completes at the next rising edge.
    initial begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        forever begin
            @(negedge ACLK);
            if (flush_req != flush_seen) begin
                flush_seen = flush_req;
                aw_got = 0; w_got = 0; ar_got = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                M_AXI_BVALID = 0; M_AXI_RVALID = 0;
            end
            if (M_AXI_BREADY && !(aw_got && w_got)) begin
                viol++; $display("protocol: BREADY before AW/W done, cycle %0d", cyc);
            end
            if (M_AXI_RREADY && !ar_got) begin
                viol++; $display("protocol: RREADY before AR done, cycle %0d", cyc);
            end
            if (aw_got && w_got) begin
                if (b_wait >= b_delay) begin
                    M_AXI_BVALID = 1; M_AXI_BRESP = bresp_cfg;
                    if (M_AXI_BREADY) begin
                        hs_b = cyc;
                        smem[got_addr] = merge(smem.exists(got_addr) ? smem[got_addr] : 32'h0, got_wdata, got_strb);
                        aw_got = 0; w_got = 0; b_wait = 0;
                    end
                end else begin
                    M_AXI_BVALID = 0; b_wait++;
                end
            end else M_AXI_BVALID = 0;
            if (M_AXI_AWVALID) begin
                if (aw_got) begin
                    viol++; M_AXI_AWREADY = 0; $display("protocol: AWVALID after handshake, cycle %0d", cyc);
                end else begin
                    if (M_AXI_AWADDR !== cur_addr || M_AXI_AWCACHE !== 4'b0011 || M_AXI_AWPROT !== 3'b000) begin
                        viol++; $display("protocol: AW fields %h/%h/%h, cycle %0d", M_AXI_AWADDR, M_AXI_AWCACHE, M_AXI_AWPROT, cyc);
                    end
                    if (aw_wait >= aw_delay) begin
                        M_AXI_AWREADY = 1; aw_got = 1; got_addr = M_AXI_AWADDR; hs_aw = cyc;
                        aw_log.push_back(M_AXI_AWADDR); aw_wait = 0;
                    end else begin
                        M_AXI_AWREADY = 0; aw_wait++;
                    end
                end
            end else begin
                M_AXI_AWREADY = 0; aw_wait = 0;
            end
            if (M_AXI_WVALID) begin
                if (w_got) begin
                    viol++; M_AXI_WREADY = 0; $display("protocol: WVALID after handshake, cycle %0d", cyc);
                end else begin
                    if (M_AXI_WDATA !== cur_wdata || M_AXI_WSTRB !== cur_be) begin
                        viol++; $display("protocol: W fields %h/%h, cycle %0d", M_AXI_WDATA, M_AXI_WSTRB, cyc);
                    end
                    if (w_wait >= w_delay) begin
                        M_AXI_WREADY = 1; w_got = 1; got_wdata = M_AXI_WDATA; got_strb = M_AXI_WSTRB;
                        hs_w = cyc; w_wait = 0;
                    end else begin
                        M_AXI_WREADY = 0; w_wait++;
                    end
                end
            end else begin
                M_AXI_WREADY = 0; w_wait = 0;
            end
            if (ar_got) begin
                if (r_wait >= r_delay) begin
                    M_AXI_RVALID = 1; M_AXI_RRESP = rresp_cfg;
                    M_AXI_RDATA = smem.exists(ar_a) ? smem[ar_a] : 32'h0;
                    if (M_AXI_RREADY) begin
                        hs_r = cyc; ar_got = 0; r_wait = 0;
                    end
                end else begin
                    M_AXI_RVALID = 0; r_wait++;
                end
            end else M_AXI_RVALID = 0;
            if (M_AXI_ARVALID && !ar_got) begin
                if (M_AXI_ARADDR !== cur_addr || M_AXI_ARCACHE !== 4'b0011 || M_AXI_ARPROT !== 3'b000) begin
                    viol++; $display("protocol: AR fields %h/%h/%h, cycle %0d", M_AXI_ARADDR, M_AXI_ARCACHE, M_AXI_ARPROT, cyc);
                end
                if (ar_wait >= ar_delay) begin
                    M_AXI_ARREADY = 1; ar_got = 1; ar_a = M_AXI_ARADDR; hs_ar = cyc; ar_wait = 0;
                end else begin
                    M_AXI_ARREADY = 0; ar_wait++;
                end
            end else begin
                if (M_AXI_ARVALID) begin
                    viol++; $display("protocol: ARVALID after handshake, cycle %0d", cyc);
                end
                M_AXI_ARREADY = 0; ar_wait = 0;
            end
        end
    end

    // Issues one command at a falling edge and waits (bounded) for LOCAL_ACK; returns observations only.
    task automatic run_cmd(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input int limit, output int t0, output int ack_at,
                           output logic [31:0] rd, output logic [1:0] rs, output logic busy1);
        for (int i = 0; i < 100 && LOCAL_BUSY; i++) @(negedge ACLK);
        cur_addr = addr; cur_wdata = wdata; cur_be = be;
        LOCAL_RNW = rnw; LOCAL_ADDR = addr; LOCAL_BE = be; LOCAL_WDATA = wdata; LOCAL_CS = 1;
        t0 = cyc;
        @(negedge ACLK);
        LOCAL_CS = 0;
        busy1 = LOCAL_BUSY;
        ack_at = -1; rd = '0; rs = '0;
        for (int i = 0; i < limit; i++) begin
            if (LOCAL_ACK) begin
                ack_at = cyc; rd = LOCAL_RDATA; rs = LOCAL_RESP;
                break;
            end
            @(negedge ACLK);
        end
    endtask

    task automatic set_delays(input int aw, input int w, input int b, input int ar, input int r);
        aw_delay = aw; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
    endtask

    task automatic test_reset();
        LOCAL_CS = 0; LOCAL_RNW = 0; LOCAL_ADDR = '0; LOCAL_BE = '0; LOCAL_WDATA = '0;
        ARESETN = 0;
        repeat (3) @(negedge ACLK);
        ARESETN = 1;
        @(negedge ACLK);
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, LOCAL_ACK, LOCAL_BUSY} !== 7'b0) begin
            errors++; $display("FAIL reset_handshake got %b exp 0000000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, LOCAL_ACK, LOCAL_BUSY});
        end
        checks++;
        if ({LOCAL_RDATA, LOCAL_RESP} !== 34'h0) begin
            errors++; $display("FAIL reset_local got %h/%h exp 0/0", LOCAL_RDATA, LOCAL_RESP);
        end
        checks++;
        if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !== 68'h0) begin
            errors++; $display("FAIL reset_captured got %h/%h/%h exp 0", M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB);
        end
        checks++;
        if ({M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_ARCACHE, M_AXI_ARPROT} !== {4'b0011, 3'b000, 4'b0011, 3'b000}) begin
            errors++; $display("FAIL reset_cache_prot got %h/%h exp 3/0", M_AXI_AWCACHE, M_AXI_AWPROT);
        end
    endtask

    task automatic test_write_zero_wait();
        int t0, ack, v0; logic [31:0] rd; logic [1:0] rs; logic b1;
        set_delays(0, 0, 0, 0, 0); bresp_cfg = 2'b00; v0 = viol;
        run_cmd(0, 32'h4, 4'hF, 32'hA5A5_1234, 20, t0, ack, rd, rs, b1);
        mmem[32'h4] = merge(model_read(32'h4), 32'hA5A5_1234, 4'hF);
        checks++; if (ack - t0 !== 3) begin errors++; $display("FAIL wr0_ack_latency got %0d exp 3", ack - t0); end
        checks++; if (hs_aw - t0 !== 1 || hs_w - t0 !== 1) begin errors++; $display("FAIL wr0_aw_w_cycle got %0d/%0d exp 1/1", hs_aw - t0, hs_w - t0); end
        checks++; if (hs_b - t0 !== 2) begin errors++; $display("FAIL wr0_b_cycle got %0d exp 2", hs_b - t0); end
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL wr0_resp got %b exp 00", rs); end
        checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL wr0_busy got %b exp 1", b1); end
        checks++; if (got_addr !== 32'h4 || got_wdata !== 32'hA5A5_1234) begin errors++; $display("FAIL wr0_slave_data got %h/%h exp 4/a5a51234", got_addr, got_wdata); end
        @(negedge ACLK);
        checks++; if (LOCAL_BUSY !== 1'b0 || LOCAL_ACK !== 1'b0) begin errors++; $display("FAIL wr0_idle got %b/%b exp 0/0", LOCAL_BUSY, LOCAL_ACK); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL wr0_protocol got %0d exp %0d", viol, v0); end
    endtask

    task automatic test_read_back();
        int t0, ack, v0; logic [31:0] rd; logic [1:0] rs; logic b1;
        set_delays(0, 0, 0, 0, 0); rresp_cfg = 2'b00; v0 = viol;
        run_cmd(1, 32'h4, 4'h0, 32'h0, 20, t0, ack, rd, rs, b1);
        checks++; if (ack - t0 !== 3) begin errors++; $display("FAIL rd0_ack_latency got %0d exp 3", ack - t0); end
        checks++; if (hs_ar - t0 !== 1 || hs_r - t0 !== 2) begin errors++; $display("FAIL rd0_ar_r_cycle got %0d/%0d exp 1/2", hs_ar - t0, hs_r - t0); end
        checks++; if (rd !== 32'hA5A5_1234) begin errors++; $display("FAIL rd0_data got %h exp a5a51234", rd); end
        checks++; if (rs !== 2'b00) begin errors++; $display("FAIL rd0_resp got %b exp 00", rs); end
        repeat (3) @(negedge ACLK);
        checks++; if (LOCAL_RDATA !== 32'hA5A5_1234) begin errors++; $display("FAIL rd0_hold got %h exp a5a51234", LOCAL_RDATA); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL rd0_protocol got %0d exp %0d", viol, v0); end
    endtask

    task automatic test_aw_delay();
        int t0, ack, v0; logic [31:0] rd; logic [1:0] rs; logic b1;
        set_delays(3, 0, 0, 0, 0); bresp_cfg = 2'b00; v0 = viol;
        run_cmd(0, 32'h8, 4'h3, 32'h1357_9BDF, 30, t0, ack, rd, rs, b1);
        mmem[32'h8] = merge(model_read(32'h8), 32'h1357_9BDF, 4'h3);
        checks++; if (hs_aw - t0 !== 4 || hs_w - t0 !== 1) begin errors++; $display("FAIL awdly_hs got aw %0d w %0d exp 4/1", hs_aw - t0, hs_w - t0); end
        checks++; if (ack - t0 !== model_lat(0) || ack - hs_b !== 1) begin errors++; $display("FAIL awdly_ack got %0d exp %0d", ack - t0, model_lat(0)); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL awdly_protocol got %0d exp %0d", viol, v0); end
    endtask

    task automatic test_bresp_err();
        int t0, ack, v0, extra; logic [31:0] rd; logic [1:0] rs; logic b1;
        set_delays(0, 1, 2, 0, 0); bresp_cfg = 2'b10; v0 = viol; extra = 0;
        run_cmd(0, 32'hC, 4'hF, 32'hDEAD_BEEF, 30, t0, ack, rd, rs, b1);
        mmem[32'hC] = 32'hDEAD_BEEF;
        checks++; if (rs !== 2'b10) begin errors++; $display("FAIL berr_resp got %b exp 10", rs); end
        checks++; if (ack - t0 !== model_lat(0)) begin errors++; $display("FAIL berr_latency got %0d exp %0d", ack - t0, model_lat(0)); end
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            if (LOCAL_ACK) extra++;
        end
        checks++; if (extra !== 0 || LOCAL_BUSY !== 1'b0) begin errors++; $display("FAIL berr_single_ack got extra %0d busy %b exp 0/0", extra, LOCAL_BUSY); end
        checks++; if (viol !== v0) begin errors++; $display("FAIL berr_protocol got %0d exp %0d", viol, v0); end
        bresp_cfg = 2'b00;
    endtask

    task automatic test_cs_held();
        int t_start, acks, n0, v0, last_ack;
        set_delays(0, 0, 0, 0, 0); bresp_cfg = 2'b00; v0 = viol; n0 = aw_log.size();
        acks = 0; last_ack = -1;
        cur_addr = 32'h100; cur_wdata = 32'h5000_0000; cur_be = 4'hF;
        LOCAL_RNW = 0; LOCAL_ADDR = cur_addr; LOCAL_WDATA = cur_wdata; LOCAL_BE = 4'hF; LOCAL_CS = 1;
        t_start = cyc;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (LOCAL_ACK) begin
                mmem[cur_addr] = cur_wdata;
                acks++; last_ack = cyc;
                if (acks == 5) begin
                    LOCAL_CS = 0;
                    break;
                end
                cur_addr = 32'h100 + 32'(4 * acks); cur_wdata = 32'h5000_0000 + 32'(acks);
                LOCAL_ADDR = cur_addr; LOCAL_WDATA = cur_wdata;
            end
        end
        LOCAL_CS = 0;
        checks++; if (acks !== 5) begin errors++; $display("FAIL csheld_acks got %0d exp 5", acks); end
        checks++; if (last_ack - t_start !== 19) begin errors++; $display("FAIL csheld_span got %0d exp 19", last_ack - t_start); end
        checks++; if (aw_log.size() - n0 !== 5) begin errors++; $display("FAIL csheld_aw_count got %0d exp 5", aw_log.size() - n0); end
        for (int k = 0; k < 5 && n0 + k < aw_log.size(); k++) begin
            checks++;
            if (aw_log[n0 + k] !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL csheld_addr%0d got %h exp %h", k, aw_log[n0 + k], 32'h100 + 32'(4 * k)); end
        end
        checks++; if (viol !== v0) begin errors++; $display("FAIL csheld_protocol got %0d exp %0d", viol, v0); end
        @(negedge ACLK);
    endtask

    task automatic test_random();
        int t0, ack, v0, lat; logic [31:0] rd, a, d; logic [1:0] rs; logic b1, rnw; logic [3:0] be;
        v0 = viol;
        for (int n = 0; n < 30; n++) begin
            rnw = 1'($urandom_range(0, 1));
            a = 32'h40 + 32'(4 * $urandom_range(0, 3));
            be = 4'($urandom); d = $urandom;
            set_delays(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
            lat = model_lat(rnw);
            run_cmd(rnw, a, be, d, 40, t0, ack, rd, rs, b1);
            checks++; if (ack - t0 !== lat) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d", n, ack - t0, lat); end
            checks++; if (rs !== (rnw ? rresp_cfg : bresp_cfg)) begin errors++; $display("FAIL rand%0d_resp got %b exp %b", n, rs, rnw ? rresp_cfg : bresp_cfg); end
            if (rnw) begin
                checks++; if (rd !== model_read(a)) begin errors++; $display("FAIL rand%0d_rdata got %h exp %h", n, rd, model_read(a)); end
            end else begin
                mmem[a] = merge(model_read(a), d, be);
            end
        end
        checks++; if (viol !== v0) begin errors++; $display("FAIL rand_protocol got %0d exp %0d", viol, v0); end
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
    endtask

    task automatic test_stall_and_reset();
        int t0, ack, acks; logic [31:0] rd; logic [1:0] rs; logic b1;
        set_delays(1000, 1000, 0, 0, 0);
        run_cmd(0, 32'h20, 4'hF, 32'h0BAD_F00D, 6, t0, ack, rd, rs, b1);
        checks++; if (ack !== -1 || {M_AXI_AWVALID, M_AXI_WVALID, LOCAL_BUSY} !== 3'b111) begin
            errors++; $display("FAIL stall_wr_pending got ack %0d valids %b exp -1/111", ack, {M_AXI_AWVALID, M_AXI_WVALID, LOCAL_BUSY});
        end
        #2 ARESETN = 0;
        #1;
        checks++; if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, LOCAL_BUSY, LOCAL_ACK} !== 7'b0) begin
            errors++; $display("FAIL async_reset_wr got %b exp 0000000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, LOCAL_BUSY, LOCAL_ACK});
        end
        set_delays(0, 0, 0, 0, 0);
        @(negedge ACLK);
        ARESETN = 1; flush_req++;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            if (LOCAL_ACK || LOCAL_BUSY) acks++;
        end
        checks++; if (acks !== 0) begin errors++; $display("FAIL lost_cmd_ack got %0d exp 0", acks); end
        set_delays(0, 0, 0, 0, 1000);
        run_cmd(1, 32'h4, 4'h0, 32'h0, 40, t0, ack, rd, rs, b1);
`ifdef AQ_AXILM_TIMEOUT_EN
        checks++; if (ack - t0 !== 17) begin errors++; $display("FAIL timeout_latency got %0d exp 17", ack - t0); end
        checks++; if (rs !== 2'b11 || rd !== 32'h0) begin errors++; $display("FAIL timeout_resp got %b/%h exp 11/0", rs, rd); end
        @(negedge ACLK);
        flush_req++;
        set_delays(0, 0, 0, 0, 0);
        @(negedge ACLK);
`else
        checks++; if (ack !== -1 || {LOCAL_BUSY, M_AXI_RREADY} !== 2'b11) begin
            errors++; $display("FAIL no_timeout_wait got ack %0d busy/rready %b exp -1/11", ack, {LOCAL_BUSY, M_AXI_RREADY});
        end
        #2 ARESETN = 0;
        #1;
        checks++; if ({LOCAL_BUSY, M_AXI_RREADY, M_AXI_ARVALID} !== 3'b000) begin
            errors++; $display("FAIL async_reset_rd got %b exp 000", {LOCAL_BUSY, M_AXI_RREADY, M_AXI_ARVALID});
        end
        set_delays(0, 0, 0, 0, 0);
        @(negedge ACLK);
        ARESETN = 1; flush_req++;
        @(negedge ACLK);
        @(negedge ACLK);
`endif
    endtask

    task automatic test_after_reset();
        int t0, ack; logic [31:0] rd; logic [1:0] rs; logic b1;
        set_delays(0, 0, 0, 0, 0); rresp_cfg = 2'b01;
        run_cmd(1, 32'h4, 4'h0, 32'h0, 20, t0, ack, rd, rs, b1);
        checks++; if (ack - t0 !== 3 || rd !== model_read(32'h4) || rs !== 2'b01) begin
            errors++; $display("FAIL post_reset_read got lat %0d data %h resp %b exp 3/%h/01", ack - t0, rd, rs, model_read(32'h4));
        end
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_back();
        test_aw_delay();
        test_bresp_err();
        test_cs_held();
        test_random();
        test_stall_and_reset();
        test_after_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
